// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int MULDIV_OP_W    = 3;
    localparam int MULDIV_STATE_W = 2;

    // Operation select, encoded exactly as the func3 field.
    typedef enum logic [MULDIV_OP_W-1:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [MULDIV_STATE_W-1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_operand_prep.sv
// Combinational operand conditioning: converts signed operands to magnitudes,
// reports their signs, and flags the cases that need no iteration at all.
module muldiv_operand_prep
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [MULDIV_OP_W-1:0] func3,
    input  logic [XLEN-1:0]        a,
    input  logic [XLEN-1:0]        b,
    output logic [XLEN-1:0]        a_mag,
    output logic [XLEN-1:0]        b_mag,
    output logic                   a_neg,
    output logic                   b_neg,
    output logic                   b_zero,
    output logic                   early_out
);

    muldiv_op_e op;
    logic       a_signed;
    logic       b_signed;
    logic       div_ovf;

    // Sign decode, magnitudes and special-case detection.
    always_comb begin
        op       = muldiv_op_e'(func3);
        // MUL keeps both operands unsigned: the low half of the product is sign-agnostic.
        a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        a_neg    = a_signed && a[XLEN-1];
        b_neg    = b_signed && b[XLEN-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
        b_zero   = (b == '0);
        div_ovf  = ((op == OP_DIV) || (op == OP_REM)) &&
                   (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
        early_out = func3[2] ? (b_zero || div_ovf) : ((a == '0) || b_zero);
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit: one shift-add or
// restoring shift-subtract step per cycle on a 2*XLEN accumulator.
// Optional macro MULDIV_EARLY_OUT_EN: trivially-resolved operations skip
// the iteration and go straight to DONE; results are identical either way.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [MULDIV_OP_W-1:0] func3,
    input  logic [XLEN-1:0]        a,
    input  logic [XLEN-1:0]        b,
    output logic                   ready,
    output logic                   busy,
    output logic                   done,
    output logic [XLEN-1:0]        result
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam int ACC_W = 2 * XLEN;

    muldiv_state_e state_q, state_d;
    muldiv_op_e    op_q;
    logic [XLEN-1:0]  a_q;      // original rs1, returned by REM/REMU on divide by zero
    logic [XLEN-1:0]  opnd_q;   // multiplicand or divisor magnitude
    logic             a_neg_q, b_neg_q, b_zero_q;
    logic [ACC_W-1:0] acc_q, acc_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  result_q;

    logic [XLEN-1:0]  a_mag, b_mag;
    logic             a_neg, b_neg, b_zero, early_out;
    logic [XLEN:0]    mul_sum, div_trial;
    logic [ACC_W-1:0] prod_fix;
    logic [XLEN-1:0]  quo, rem, fin_res;
    logic             prod_neg, last_step;

    muldiv_operand_prep #(.XLEN(XLEN)) u_prep (
        .func3     (func3),
        .a         (a),
        .b         (b),
        .a_mag     (a_mag),
        .b_mag     (b_mag),
        .a_neg     (a_neg),
        .b_neg     (b_neg),
        .b_zero    (b_zero),
        .early_out (early_out)
    );

`ifdef MULDIV_EARLY_OUT_EN
    logic [XLEN-1:0] early_res;

    // Result of the cases resolved without iterating, from the raw operands.
    always_comb begin
        if (!func3[2])     early_res = '0;
        else if (b_zero)   early_res = func3[1] ? a : '1;
        else               early_res = func3[1] ? '0 : a;
    end
`else
    logic unused_early_out;
    assign unused_early_out = early_out;
`endif

    assign last_step = (cnt_q == CNT_W'(XLEN - 1));

    // One iteration step of the accumulator.
    always_comb begin
        mul_sum   = {1'b0, acc_q[ACC_W-1:XLEN]} + ({1'b0, opnd_q} & {(XLEN+1){acc_q[0]}});
        div_trial = acc_q[ACC_W-1:XLEN-1] - {1'b0, opnd_q};
        if (op_q[2]) begin
            if (!div_trial[XLEN]) acc_nxt = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            else                  acc_nxt = {acc_q[ACC_W-2:0], 1'b0};
        end else begin
            acc_nxt = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    // Sign fix-up and result selection from the final accumulator value.
    always_comb begin
        prod_neg = a_neg_q ^ b_neg_q;
        prod_fix = prod_neg ? -acc_nxt : acc_nxt;
        quo      = acc_nxt[XLEN-1:0];
        rem      = acc_nxt[ACC_W-1:XLEN];
        case (op_q)
            OP_MUL:                       fin_res = quo;
            OP_MULH, OP_MULHSU, OP_MULHU: fin_res = prod_fix[ACC_W-1:XLEN];
            OP_DIV, OP_DIVU:              fin_res = b_zero_q ? '1 : (prod_neg ? -quo : quo);
            OP_REM, OP_REMU:              fin_res = b_zero_q ? a_q : (a_neg_q ? -rem : rem);
            default:                      fin_res = quo;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
`ifdef MULDIV_EARLY_OUT_EN
                    state_d = early_out ? DONE : BUSY;
`else
                    state_d = BUSY;
`endif
                end
            end
            BUSY:    if (last_step) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        ready  = (state_q == IDLE);
        busy   = (state_q == BUSY);
        done   = (state_q == DONE);
        result = result_q;
    end

    // Datapath: operand capture on accept, iteration while busy, result on last step.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= OP_MUL;
            a_q      <= '0;
            opnd_q   <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            b_zero_q <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q     <= muldiv_op_e'(func3);
                        a_q      <= a;
                        a_neg_q  <= a_neg;
                        b_neg_q  <= b_neg;
                        b_zero_q <= b_zero;
                        cnt_q    <= '0;
                        if (func3[2]) begin
                            opnd_q <= b_mag;
                            acc_q  <= {{XLEN{1'b0}}, a_mag};
                        end else begin
                            opnd_q <= a_mag;
                            acc_q  <= {{XLEN{1'b0}}, b_mag};
                        end
`ifdef MULDIV_EARLY_OUT_EN
                        if (early_out) result_q <= early_res;
`endif
                    end
                end
                BUSY: begin
                    acc_q <= acc_nxt;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_step) result_q <= fin_res;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: a 32-bit and an 8-bit instance, directed vectors.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, start8;
    logic [2:0]  func3, func3_8;
    logic [31:0] a, b, result;
    logic [7:0]  a8, b8, result8;
    logic        ready, busy, done, ready8, busy8, done8;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_run = 0, busy_run8 = 0;
    int done_cnt = 0;
    logic [31:0] last_res;
    logic [7:0]  last_res8;

    logic [31:0] exp_q[$];
    int          acc_q[$];
    string       name_q[$];
    logic [7:0]  exp8_q[$];
    int          acc8_q[$];

    muldiv_unit #(.XLEN(32)) u_dut (
        .clk(clk), .reset(reset), .start(start), .func3(func3), .a(a), .b(b),
        .ready(ready), .busy(busy), .done(done), .result(result)
    );

    muldiv_unit #(.XLEN(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .func3(func3_8), .a(a8), .b(b8),
        .ready(ready8), .busy(busy8), .done(done8), .result(result8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor for the 32-bit instance.
    always @(negedge clk) begin
        if (reset) begin
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'(result), 64'hDEAD);
                end else begin
                    check({name_q[0], "_res"}, 64'(result), 64'(exp_q[0]));
                    check({name_q[0], "_lat"}, 64'(cyc - acc_q[0]), 64'd32);
                    check({name_q[0], "_busy"}, 64'(busy_run), 64'd32);
                    check({name_q[0], "_rdy"}, 64'(ready), 64'd0);
                    void'(exp_q.pop_front());
                    void'(acc_q.pop_front());
                    void'(name_q.pop_front());
                end
                busy_run = 0;
            end
        end
    end

    // Monitor for the 8-bit instance.
    always @(negedge clk) begin
        if (reset) begin
            busy_run8 = 0;
        end else begin
            if (busy8) busy_run8++;
            if (done8) begin
                if (exp8_q.size() == 0) begin
                    check("unexpected_done8", 64'(result8), 64'hDEAD);
                end else begin
                    check("x8_res", 64'(result8), 64'(exp8_q[0]));
                    check("x8_lat", 64'(cyc - acc8_q[0]), 64'd8);
                    check("x8_busy", 64'(busy_run8), 64'd8);
                    void'(exp8_q.pop_front());
                    void'(acc8_q.pop_front());
                end
                busy_run8 = 0;
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_timeout", 64'(ready), 64'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
        exp_q.delete(); acc_q.delete(); name_q.delete();
    endtask

    // Issue one 32-bit op, scramble the inputs afterwards, and wait for completion.
    task automatic run_op(input logic [2:0] op, input logic [31:0] aa, input logic [31:0] bb,
                          input logic [31:0] exp, input string name);
        wait_ready();
        check({name, "_hold"}, 64'(result), 64'(last_res));
        func3 = op; a = aa; b = bb; start = 1'b1;
        exp_q.push_back(exp); acc_q.push_back(cyc + 1); name_q.push_back(name);
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; func3 = 3'($urandom);
        drain();
        last_res = exp;
    endtask

    task automatic run_op8(input logic [2:0] op, input logic [7:0] aa, input logic [7:0] bb,
                           input logic [7:0] exp);
        int n = 0;
        while (!ready8 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("x8_hold", 64'(result8), 64'(last_res8));
        func3_8 = op; a8 = aa; b8 = bb; start8 = 1'b1;
        exp8_q.push_back(exp); acc8_q.push_back(cyc + 1);
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        n = 0;
        while (exp8_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("x8_timeout", 64'(exp8_q.size()), 64'd0);
        exp8_q.delete(); acc8_q.delete();
        last_res8 = exp;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        reset = 1'b1; start = 1'b0; func3 = '0; a = '0; b = '0;
        start8 = 1'b0; func3_8 = '0; a8 = '0; b8 = '0;
        last_res = '0; last_res8 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_ready8", 64'(ready8), 64'd1);
        @(posedge clk); #1;
        reset = 1'b0;

        run_op(3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, "mul");
        run_op(3'b000, 32'h12345678, 32'd0,        32'd0,        "mul_zero");
        run_op(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, "mulh");
        run_op(3'b001, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, "mulh_neg");
        run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu");
        run_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu");
        run_op(3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, "div");
        run_op(3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, "rem");
        run_op(3'b101, 32'd100,      32'd7,        32'd14,       "divu");
        run_op(3'b111, 32'd100,      32'd7,        32'd2,        "remu");
        run_op(3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, "divu_z");
        run_op(3'b111, 32'd5,        32'd0,        32'd5,        "remu_z");
        run_op(3'b100, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, "div_z");
        run_op(3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, "rem_z");
        run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf");
        run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        "rem_ovf");

        // start held high through most of BUSY: one completion only.
        wait_ready();
        dc = done_cnt;
        func3 = 3'b000; a = 32'd3; b = 32'd5; start = 1'b1;
        exp_q.push_back(32'd15); acc_q.push_back(cyc + 1); name_q.push_back("ign");
        @(posedge clk); #1;
        func3 = 3'b100; a = 32'd9; b = 32'd9;
        repeat (20) @(posedge clk);
        #1 start = 1'b0;
        drain();
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("ign_count", 64'(done_cnt - dc), 64'd1);
        check("ign_result", 64'(result), 64'd15);
        last_res = 32'd15;

        // Reset at BUSY cycle 10, with start asserted on the same edge.
        @(posedge clk); #1;
        func3 = 3'b101; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dc = done_cnt;
        repeat (9) @(posedge clk);
        #1 reset = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        check("mid_rst_ready", 64'(ready), 64'd1);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_result", 64'(result), 64'd0);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("no_late_done", 64'(done_cnt - dc), 64'd0);
        last_res = '0;
        last_res8 = '0;
        @(posedge clk); #1;

        run_op(3'b011, 32'd3, 32'd4, 32'd0, "post_rst_mulhu");

        run_op8(3'b000, 8'h0F, 8'h11, 8'hFF);
        run_op8(3'b100, 8'h80, 8'hFF, 8'h80);
        run_op8(3'b110, 8'hF9, 8'h02, 8'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
